fifo_rd_stream: RTL and testbench

Read-side adapter placed directly downstream of the async FIFO's read port, in the rclk domain. It converts the FIFO's r_en/empty/data_out interface into a valid/ready stream. It pops only when the FIFO is not empty and buffer space is guaranteed, and it absorbs the FIFO's 1-cycle registered read latency in a 2-entry output buffer, so throughput is 1 word/cycle with no data loss under arbitrary back-pressure.

---
 rtl/fifo_rd_stream.sv | 67 ++++++
 tb/tb_fifo_rd_stream.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side adapter for the async FIFO: turns r_en/empty/data_out into a valid/ready
// stream, absorbing the FIFO's one-cycle read latency in a 2-entry skid buffer.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  xfer_cnt
);

  logic                  inflight_q, inflight_d;
  logic [1:0]            occ_q, occ_d;
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  hs;
  logic [1:0]            level;

  // level = words buffered after this edge, counting the one already in flight;
  // a new pop is allowed only if it still fits.
  always_comb begin
    m_valid    = !rrst && (occ_q != 2'd0);
    m_data     = mem_q[head_q];
    hs         = m_valid && m_ready;
    level      = occ_q + {1'b0, inflight_q} - {1'b0, hs};
    fifo_r_en  = !rrst && !fifo_empty && (level < 2'd2);
    inflight_d = fifo_r_en;
    occ_d      = level;
    tail_d     = tail_q ^ inflight_q;
    head_d     = head_q ^ hs;
    cnt_d      = cnt_q + {{(CNT_WIDTH-1){1'b0}}, hs};
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
    end
  end

  // Buffer storage carries no reset; occ_q alone decides what is meaningful.
  always_ff @(posedge rclk) begin
    if (!rrst && inflight_q) begin
      mem_q[tail_q] <= fifo_data;
    end
  end

  assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural FIFO read port in front of it.
module tb_fifo_rd_stream;
  localparam int DW = 8;

  logic          rclk = 1'b0;
  logic          rrst;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          m_ready;
  logic          fifo_r_en, m_valid;
  logic [DW-1:0] m_data;
  logic [15:0]   xfer_cnt;
  logic          fifo_r_en2, m_valid2;
  logic [DW-1:0] m_data2;
  logic [3:0]    xfer_cnt2;

  int checks = 0;
  int errors = 0;

  logic [7:0] fmem [1024];
  logic [9:0] wr_ptr = '0;
  logic [9:0] rd_ptr = '0;
  logic       flush_req = 1'b0;

  always #5 rclk = ~rclk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  // FIFO read port: data_out registered on r_en, valid the following cycle.
  always @(posedge rclk) begin
    if (flush_req) rd_ptr <= wr_ptr;
    else if (fifo_r_en) begin
      if (!fifo_empty) begin
        fifo_data <= fmem[rd_ptr];
        rd_ptr    <= rd_ptr + 10'd1;
      end else begin
        fifo_data <= 8'hEE;
      end
    end
  end

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
    .rclk(rclk), .rrst(rrst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_r_en(fifo_r_en), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .xfer_cnt(xfer_cnt)
  );

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut_w4 (
    .rclk(rclk), .rrst(rrst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_r_en(fifo_r_en2), .m_valid(m_valid2), .m_ready(m_ready),
    .m_data(m_data2), .xfer_cnt(xfer_cnt2)
  );

  task automatic push(input logic [7:0] v);
    fmem[wr_ptr] = v;
    wr_ptr = wr_ptr + 10'd1;
  endtask

  function automatic logic [7:0] word(input int i);
    return 8'((i * 7) + 3);
  endfunction

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge rclk);
      rrst = 1'b1;
      #1;
      checks++;
      if (fifo_r_en !== 1'b0 || m_valid !== 1'b0 || xfer_cnt !== 16'd0) begin
        errors++;
        $display("FAIL reset cyc%0d: r_en=%b valid=%b cnt=%0d, required 0 0 0",
                 c, fifo_r_en, m_valid, xfer_cnt);
      end
    end
  endtask

  task automatic test_streaming();
    logic exp_ren, exp_v;
    for (int i = 0; i < 12; i++) begin
      @(negedge rclk);
      rrst = 1'b0;
      m_ready = 1'b1;
      #1;
      exp_ren = (i < 8);
      exp_v   = (i >= 2) && (i < 10);
      checks++;
      if (fifo_r_en !== exp_ren) begin
        errors++;
        $display("FAIL stream r_en cyc%0d: got %b, required %b", i, fifo_r_en, exp_ren);
      end
      checks++;
      if (m_valid !== exp_v) begin
        errors++;
        $display("FAIL stream valid cyc%0d: got %b, required %b", i, m_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (m_data !== 8'(i - 1)) begin
          errors++;
          $display("FAIL stream data cyc%0d: got %h, required %h", i, m_data, 8'(i - 1));
        end
      end
    end
    @(negedge rclk);
    #1;
    checks++;
    if (xfer_cnt !== 16'd8) begin
      errors++;
      $display("FAIL stream cnt: got %0d, required 8", xfer_cnt);
    end
  endtask

  task automatic test_back_pressure();
    int pops = 0;
    logic exp_ren, exp_v;
    for (int j = 0; j < 10; j++) begin
      @(negedge rclk);
      if (j == 0) for (int w = 0; w < 5; w++) push(8'h10 + 8'(w));
      m_ready = 1'b0;
      #1;
      pops += int'(fifo_r_en);
      exp_ren = (j < 2);
      exp_v   = (j >= 2);
      checks++;
      if (fifo_r_en !== exp_ren || m_valid !== exp_v) begin
        errors++;
        $display("FAIL bp hold cyc%0d: r_en=%b valid=%b, required %b %b",
                 j, fifo_r_en, m_valid, exp_ren, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (m_data !== 8'h10) begin
          errors++;
          $display("FAIL bp stable cyc%0d: got %h, required 10", j, m_data);
        end
      end
    end
    checks++;
    if (pops != 2) begin
      errors++;
      $display("FAIL bp pops: got %0d, required 2", pops);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge rclk);
      m_ready = 1'b1;
      #1;
      exp_ren = (k < 3);
      exp_v   = (k < 5);
      checks++;
      if (fifo_r_en !== exp_ren || m_valid !== exp_v) begin
        errors++;
        $display("FAIL bp drain cyc%0d: r_en=%b valid=%b, required %b %b",
                 k, fifo_r_en, m_valid, exp_ren, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (m_data !== 8'h10 + 8'(k)) begin
          errors++;
          $display("FAIL bp data cyc%0d: got %h, required %h", k, m_data, 8'h10 + 8'(k));
        end
      end
      if (k == 5) begin
        checks++;
        if (xfer_cnt !== 16'd13) begin
          errors++;
          $display("FAIL bp cnt: got %0d, required 13", xfer_cnt);
        end
      end
    end
  endtask

  task automatic test_empty_edge();
    logic exp_ren, exp_v;
    for (int c = 0; c < 6; c++) begin
      @(negedge rclk);
      if (c == 0) push(8'hAA);
      m_ready = 1'b1;
      #1;
      exp_ren = (c == 0);
      exp_v   = (c == 2);
      checks++;
      if (fifo_r_en !== exp_ren || m_valid !== exp_v) begin
        errors++;
        $display("FAIL empty cyc%0d: r_en=%b valid=%b, required %b %b",
                 c, fifo_r_en, m_valid, exp_ren, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (m_data !== 8'hAA) begin
          errors++;
          $display("FAIL empty data: got %h, required aa", m_data);
        end
      end
    end
    checks++;
    if (xfer_cnt !== 16'd14) begin
      errors++;
      $display("FAIL empty cnt: got %0d, required 14", xfer_cnt);
    end
  endtask

  task automatic test_random_stall();
    int rx = 0, tx = 0, outstanding = 0, cyc = 0;
    logic prev_v = 1'b0, prev_r = 1'b0;
    logic [7:0] prev_d = '0;
    while (rx < 200 && cyc < 3000) begin
      @(negedge rclk);
      if (tx < 200 && $urandom_range(0, 2) != 0) begin
        push(word(tx));
        tx++;
      end
      m_ready = 1'($urandom_range(0, 1));
      #1;
      if (fifo_r_en && fifo_empty) begin
        checks++;
        errors++;
        $display("FAIL rnd pop-on-empty cyc%0d", cyc);
      end
      if (prev_v && !prev_r) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== prev_d) begin
          errors++;
          $display("FAIL rnd stable cyc%0d: valid=%b data=%h, required 1 %h",
                   cyc, m_valid, m_data, prev_d);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== word(rx)) begin
          errors++;
          $display("FAIL rnd data #%0d: got %h, required %h", rx, m_data, word(rx));
        end
        rx++;
      end
      outstanding += int'(fifo_r_en) - int'(m_valid && m_ready);
      if (outstanding > 2 || outstanding < 0) begin
        checks++;
        errors++;
        $display("FAIL rnd occupancy cyc%0d: got %0d, required 0..2", cyc, outstanding);
      end
      prev_v = m_valid;
      prev_r = m_ready;
      prev_d = m_data;
      cyc++;
    end
    checks++;
    if (rx != 200) begin
      errors++;
      $display("FAIL rnd timeout: got %0d words, required 200", rx);
    end
    @(negedge rclk);
    #1;
    checks++;
    if (xfer_cnt !== 16'd214) begin
      errors++;
      $display("FAIL rnd cnt: got %0d, required 214", xfer_cnt);
    end
  endtask

  task automatic test_mid_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge rclk);
      if (c == 0) for (int w = 0; w < 3; w++) push(8'h31 + 8'(w));
      m_ready = 1'b0;
      #1;
    end
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h31) begin
      errors++;
      $display("FAIL midrst pre: valid=%b data=%h, required 1 31", m_valid, m_data);
    end
    @(negedge rclk);
    rrst = 1'b1;
    flush_req = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b0 || fifo_r_en !== 1'b0) begin
      errors++;
      $display("FAIL midrst gate: valid=%b r_en=%b, required 0 0", m_valid, fifo_r_en);
    end
    @(negedge rclk);
    rrst = 1'b0;
    flush_req = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || xfer_cnt !== 16'd0 || xfer_cnt2 !== 4'd0) begin
      errors++;
      $display("FAIL midrst after: valid=%b cnt=%0d cnt4=%0d, required 0 0 0",
               m_valid, xfer_cnt, xfer_cnt2);
    end
  endtask

  task automatic test_wrap();
    int rx = 0, cyc = 0;
    while (rx < 17 && cyc < 100) begin
      @(negedge rclk);
      if (cyc == 0) for (int w = 0; w < 17; w++) push(8'h40 + 8'(w));
      m_ready = 1'b1;
      #1;
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== 8'h40 + 8'(rx) || m_data2 !== m_data || m_valid2 !== m_valid ||
            fifo_r_en2 !== fifo_r_en) begin
          errors++;
          $display("FAIL wrap data #%0d: got %h/%h, required %h", rx, m_data, m_data2,
                   8'h40 + 8'(rx));
        end
        rx++;
      end
      cyc++;
    end
    checks++;
    if (rx != 17) begin
      errors++;
      $display("FAIL wrap timeout: got %0d words, required 17", rx);
    end
    @(negedge rclk);
    #1;
    checks++;
    if (xfer_cnt !== 16'd17 || xfer_cnt2 !== 4'd1) begin
      errors++;
      $display("FAIL wrap cnt: got %0d/%0d, required 17/1", xfer_cnt, xfer_cnt2);
    end
  endtask

  initial begin
    rrst = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(8'(i + 1));
    test_reset();
    test_streaming();
    test_back_pressure();
    test_empty_edge();
    test_random_stall();
    test_mid_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
